// File: rtl/signature_analyzer_ctrl.sv
// rtl/signature_analyzer_ctrl.sv - CUT clear / MISR response compactor controller
// Clears the CUT, folds SAMPLE_COUNT samples into a MISR, then holds the signature.
module signature_analyzer_ctrl #(
    parameter int               DATA_W       = 8,
    parameter int               SIG_W        = 16,
    parameter logic [SIG_W-1:0] POLY         = 16'h1021,
    parameter logic [SIG_W-1:0] SEED         = 16'h0000,
    parameter int               SAMPLE_COUNT = 16
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              dut_clear,
    output logic              sample_en,
    output logic              busy,
    output logic              sig_valid,
    output logic [SIG_W-1:0]  signature
);

    localparam int CW = $clog2(SAMPLE_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_COUNT - 1);

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [SIG_W-1:0] misr_next;

    always_comb begin
        misr_next = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(data_in);
    end

    // Datapath registers only move in CLR and RUN, so DONE freezes the signature.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state     <= IDLE;
            signature <= '0;
            count     <= '0;
        end else begin
            state <= state_next;
            case (state)
                CLR: begin
                    signature <= SEED;
                    count     <= '0;
                end
                RUN: begin
                    signature <= misr_next;
                    count     <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CLR;
            CLR:     state_next = RUN;
            RUN:     if (count == LAST) state_next = DONE;
            DONE:    if (start) state_next = CLR;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dut_clear = 1'b0;
        sample_en = 1'b0;
        busy      = 1'b0;
        sig_valid = 1'b0;
        case (state)
            CLR: begin
                dut_clear = 1'b1;
                busy      = 1'b1;
            end
            RUN: begin
                sample_en = 1'b1;
                busy      = 1'b1;
            end
            DONE:    sig_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_signature_analyzer_ctrl.sv
// tb/tb_signature_analyzer_ctrl.sv - self-checking bench for signature_analyzer_ctrl
module tb_signature_analyzer_ctrl;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic [3:0]  start_v = 4'h0;
    logic [7:0]  data_in = 8'h00;
    logic [3:0]  dclr, sen, bsy, sv;
    logic [15:0] sig [4];

    logic [7:0]  dat [16];
    int          vectors = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    // Instances 0..3 run with SAMPLE_COUNT 2, 10, 1 and 16.
    signature_analyzer_ctrl #(.SAMPLE_COUNT(2)) u_sc2 (
        .clk(clk), .clear_n(clear_n), .start(start_v[0]), .data_in(data_in),
        .dut_clear(dclr[0]), .sample_en(sen[0]), .busy(bsy[0]),
        .sig_valid(sv[0]), .signature(sig[0]));
    signature_analyzer_ctrl #(.SAMPLE_COUNT(10)) u_sc10 (
        .clk(clk), .clear_n(clear_n), .start(start_v[1]), .data_in(data_in),
        .dut_clear(dclr[1]), .sample_en(sen[1]), .busy(bsy[1]),
        .sig_valid(sv[1]), .signature(sig[1]));
    signature_analyzer_ctrl #(.SAMPLE_COUNT(1)) u_sc1 (
        .clk(clk), .clear_n(clear_n), .start(start_v[2]), .data_in(data_in),
        .dut_clear(dclr[2]), .sample_en(sen[2]), .busy(bsy[2]),
        .sig_valid(sv[2]), .signature(sig[2]));
    signature_analyzer_ctrl #(.SAMPLE_COUNT(16)) u_sc16 (
        .clk(clk), .clear_n(clear_n), .start(start_v[3]), .data_in(data_in),
        .dut_clear(dclr[3]), .sample_en(sen[3]), .busy(bsy[3]),
        .sig_valid(sv[3]), .signature(sig[3]));

    // Reference signature: the first n entries of dat folded into a polynomial register.
    function automatic logic [15:0] ref_sig(input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            s = ((s * 2) % 65536) ^ ((s >= 32768) ? 32'h1021 : 0) ^ int'(dat[i]);
        end
        return s[15:0];
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic kick(input int idx);
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(negedge clk);
    endtask

    // Entered at the negedge inside CLR; returns at the first negedge inside DONE.
    task automatic body(input int idx, input int n, input int pulse_j, input bit keep);
        chk1("clr_dut_clear", dclr[idx], 1'b1);
        chk1("clr_busy", bsy[idx], 1'b1);
        chk1("clr_sample_en", sen[idx], 1'b0);
        chk1("clr_sig_valid", sv[idx], 1'b0);
        if (!keep) start_v[idx] = 1'b0;
        data_in = 8'($urandom);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            chk1("run_sample_en", sen[idx], 1'b1);
            chk1("run_dut_clear", dclr[idx], 1'b0);
            chk1("run_busy", bsy[idx], 1'b1);
            chk1("run_sig_valid", sv[idx], 1'b0);
            chk16("run_prefix_sig", sig[idx], ref_sig(j));
            data_in = dat[j];
            if (j == pulse_j) start_v[idx] = 1'b1;
            else if (!keep) start_v[idx] = 1'b0;
        end
        @(negedge clk);
        data_in = 8'($urandom);
        chk1("done_sig_valid", sv[idx], 1'b1);
        chk1("done_busy", bsy[idx], 1'b0);
        chk1("done_sample_en", sen[idx], 1'b0);
        chk1("done_dut_clear", dclr[idx], 1'b0);
        chk16("done_sig", sig[idx], ref_sig(n));
    endtask

    task automatic hold_check(input int idx, input int n);
        @(negedge clk);
        data_in = 8'($urandom);
        chk1("hold_sig_valid", sv[idx], 1'b1);
        chk16("hold_sig", sig[idx], ref_sig(n));
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk1({tag, "_dut_clear"}, dclr[i], 1'b0);
            chk1({tag, "_sample_en"}, sen[i], 1'b0);
            chk1({tag, "_busy"}, bsy[i], 1'b0);
            chk1({tag, "_sig_valid"}, sv[i], 1'b0);
            chk16({tag, "_sig"}, sig[i], 16'h0000);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset dominates a held start.
        clear_n = 1'b0;
        start_v = 4'hf;
        data_in = 8'($urandom);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        start_v = 4'h0;
        clear_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Basic two-sample run.
        dat[0] = 8'hAA; dat[1] = 8'h55;
        kick(0);
        body(0, 2, -1, 1'b0);
        chk16("s2_const", sig[0], 16'h0101);
        hold_check(0, 2);

        // Feedback tap exercised by shifting a single 1 out of the top bit.
        dat[0] = 8'h80;
        for (int i = 1; i < 10; i++) dat[i] = 8'h00;
        kick(1);
        body(1, 10, -1, 1'b0);
        chk16("s3_const", sig[1], 16'h1021);

        // start pulsed during RUN must not restart or extend the run.
        dat[0] = 8'hFF; dat[1] = 8'h00;
        kick(0);
        body(0, 2, 0, 1'b0);
        chk16("s4_const", sig[0], 16'h01FE);
        hold_check(0, 2);

        // Reset in the middle of a long run.
        for (int i = 0; i < 16; i++) dat[i] = 8'($urandom);
        kick(3);
        start_v[3] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            data_in = dat[j];
        end
        chk1("mid_busy", bsy[3], 1'b1);
        clear_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        clear_n = 1'b1;
        @(negedge clk);
        chk1("midrst_idle_busy", bsy[3], 1'b0);
        dat[0] = 8'hAA; dat[1] = 8'h55;
        kick(0);
        body(0, 2, -1, 1'b0);
        chk16("s5_const", sig[0], 16'h0101);

        // start held through DONE: one DONE cycle, immediate re-clear, same result.
        kick(0);
        body(0, 2, -1, 1'b1);
        @(negedge clk);
        body(0, 2, -1, 1'b0);
        chk16("s6_const", sig[0], 16'h0101);

        // Single-sample runs.
        for (int r = 0; r < 3; r++) begin
            dat[0] = 8'($urandom);
            kick(2);
            body(2, 1, -1, 1'b0);
            hold_check(2, 1);
        end

        // Randomized full-length runs.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) dat[i] = 8'($urandom);
            kick(3);
            body(3, 16, int'($urandom_range(0, 13)), 1'b0);
            hold_check(3, 16);
            kick(1);
            body(1, 10, -1, 1'b0);
            hold_check(1, 10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
